// File: rtl/ecpri_frame_loader_if.sv
// Port bundle for ecpri_frame_loader: MAC-side byte stream, RAM port-0
// write controls, frame notification handshake and statistics.
interface ecpri_frame_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_err;
   logic                  in_ready;

   logic [ADDR_WIDTH-1:0] addr_0;
   logic [DATA_WIDTH-1:0] data_0;
   logic                  cs_0;
   logic                  we_0;
   logic                  oe_0;

   logic                  recv_pkt;
   logic [ADDR_WIDTH-1:0] pkt_len;
   logic                  pkt_done;

   logic [15:0]           frames_ok;
   logic [15:0]           frames_drop;

   // Stream source / buffer consumer side.
   modport master (
      output in_valid, in_data, in_last, in_err, pkt_done,
      input  in_ready, addr_0, data_0, cs_0, we_0, oe_0,
      input  recv_pkt, pkt_len, frames_ok, frames_drop
   );

   // Frame loader side.
   modport slave (
      input  in_valid, in_data, in_last, in_err, pkt_done,
      output in_ready, addr_0, data_0, cs_0, we_0, oe_0,
      output recv_pkt, pkt_len, frames_ok, frames_drop
   );
endinterface

// File: rtl/ecpri_frame_loader.sv
// Loads Ethernet frames byte-by-byte into port 0 of the receive packet RAM,
// keeps only eCPRI frames (EtherType 0xAEFE) of legal length, announces each
// kept frame to ecpri_rx and waits for it to release the buffer.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for byte 0; a one-byte frame is dropped right here
// S_RECV      | writing bytes, checking EtherType and maximum length
// S_DISCARD   | frame already rejected, swallow bytes until in_last
// S_NOTIFY    | last write in flight; recv_pkt is raised on the next cycle
// S_WAIT_DONE | buffer owned by ecpri_rx, stream stalled until pkt_done
module ecpri_frame_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int MAX_LEN    = 1500,
   parameter int MIN_LEN    = 18
) (
   input logic                 clk,
   input logic                 reset,
   ecpri_frame_loader_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] IDX_ET_HI = ADDR_WIDTH'(12);
   localparam logic [ADDR_WIDTH-1:0] IDX_ET_LO = ADDR_WIDTH'(13);
   localparam logic [ADDR_WIDTH-1:0] MAX_L     = ADDR_WIDTH'(MAX_LEN);
   localparam logic [ADDR_WIDTH-1:0] MIN_L     = ADDR_WIDTH'(MIN_LEN);
   localparam logic [DATA_WIDTH-1:0] ET_HI     = DATA_WIDTH'(8'hAE);
   localparam logic [DATA_WIDTH-1:0] ET_LO     = DATA_WIDTH'(8'hFE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_DISCARD,
      S_NOTIFY,
      S_WAIT_DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] cnt_nxt;
   logic [ADDR_WIDTH-1:0] frame_len;
   logic [ADDR_WIDTH-1:0] pkt_len_q;
   logic [ADDR_WIDTH-1:0] pkt_len_nxt;
   logic                  in_ready_c;
   logic                  accept;
   logic                  hdr_bad;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  drop;
   logic                  notify;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  cs_q;
   logic                  we_q;
   logic                  oe_q;
   logic                  recv_q;
   logic [15:0]           ok_q;
   logic [15:0]           drop_q;

   // The stream is open in every state that can take a byte.
   assign in_ready_c = (state == S_IDLE) || (state == S_RECV) || (state == S_DISCARD);
   assign accept     = bus.in_valid && in_ready_c;
   assign frame_len  = cnt + ADDR_WIDTH'(1);
   assign hdr_bad    = ((cnt == IDX_ET_HI) && (bus.in_data != ET_HI)) ||
                       ((cnt == IDX_ET_LO) && (bus.in_data != ET_LO));

   // State and byte-index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, RAM write request and frame verdict.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pkt_len_nxt = pkt_len_q;
      wr_en       = 1'b0;
      wr_addr     = cnt;
      drop        = 1'b0;
      notify      = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (accept) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               if (bus.in_last) begin
                  drop = 1'b1;
               end else begin
                  cnt_nxt   = ADDR_WIDTH'(1);
                  state_nxt = S_RECV;
               end
            end
         end

         S_RECV: begin
            if (accept) begin
               if (cnt == MAX_L) begin
                  // Oversized: this byte has no room in the buffer.
                  if (bus.in_last) begin
                     drop      = 1'b1;
                     state_nxt = S_IDLE;
                  end else begin
                     state_nxt = S_DISCARD;
                  end
               end else begin
                  wr_en = 1'b1;
                  if (bus.in_last) begin
                     if ((frame_len < MIN_L) || bus.in_err || hdr_bad) begin
                        drop      = 1'b1;
                        state_nxt = S_IDLE;
                     end else begin
                        pkt_len_nxt = frame_len;
                        state_nxt   = S_NOTIFY;
                     end
                  end else if (hdr_bad) begin
                     state_nxt = S_DISCARD;
                  end else begin
                     cnt_nxt = frame_len;
                  end
               end
            end
         end

         S_DISCARD: begin
            if (accept && bus.in_last) begin
               drop      = 1'b1;
               state_nxt = S_IDLE;
            end
         end

         S_NOTIFY: begin
            notify    = 1'b1;
            state_nxt = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (bus.pkt_done) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered RAM port: the write issued on an accepted beat is presented
   // for exactly one cycle, so the RAM latches it on the following edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         data_q <= '0;
         cs_q   <= 1'b0;
         we_q   <= 1'b0;
         oe_q   <= 1'b1;
      end else if (wr_en) begin
         addr_q <= wr_addr;
         data_q <= bus.in_data;
         cs_q   <= 1'b1;
         we_q   <= 1'b1;
         oe_q   <= 1'b0;
      end else begin
         cs_q   <= 1'b0;
         we_q   <= 1'b0;
         oe_q   <= 1'b1;
      end
   end

   // Notification pulse lands one cycle after the last write, once the
   // final byte is already in RAM; pkt_len stays put until the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         recv_q    <= 1'b0;
         pkt_len_q <= '0;
      end else begin
         recv_q    <= notify;
         pkt_len_q <= pkt_len_nxt;
      end
   end

   // Saturating frame statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         ok_q   <= '0;
         drop_q <= '0;
      end else begin
         if (notify && (ok_q != 16'hFFFF)) begin
            ok_q <= ok_q + 16'd1;
         end
         if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
         end
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.addr_0      = addr_q;
   assign bus.data_0      = data_q;
   assign bus.cs_0        = cs_q;
   assign bus.we_0        = we_q;
   assign bus.oe_0        = oe_q;
   assign bus.recv_pkt    = recv_q;
   assign bus.pkt_len     = pkt_len_q;
   assign bus.frames_ok   = ok_q;
   assign bus.frames_drop = drop_q;

endmodule

// File: tb/tb_ecpri_frame_loader.sv
// Bench for ecpri_frame_loader: random frame contents and gaps, compared
// against a frame-level model (good/drop verdict, expected write list).
module tb_ecpri_frame_loader;

   localparam int DW      = 8;
   localparam int AW      = 16;
   localparam int MAX_LEN = 1500;
   localparam int MIN_LEN = 18;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   ecpri_frame_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ecpri_frame_loader #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .MAX_LEN   (MAX_LEN),
      .MIN_LEN   (MIN_LEN)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [7:0]    frm_q[$];
   logic [AW-1:0] wr_a_q[$];
   logic [7:0]    wr_d_q[$];
   int            rx_cyc_q[$];
   logic [AW-1:0] rx_len_q[$];
   int            last_acc_cyc = 0;
   bit            driving      = 1'b0;
   int            ready_low    = 0;
   int            oe_bad       = 0;
   int            exp_ok       = 0;
   int            exp_drop     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Observe everything mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.cs_0 && bus.we_0) begin
            wr_a_q.push_back(bus.addr_0);
            wr_d_q.push_back(bus.data_0);
            if (bus.oe_0) oe_bad++;
         end
         if (bus.recv_pkt) begin
            rx_cyc_q.push_back(cyc);
            rx_len_q.push_back(bus.pkt_len);
         end
         if (bus.in_valid && bus.in_ready && bus.in_last) last_acc_cyc = cyc;
         if (driving && !bus.in_ready) ready_low++;
      end
   end

   // mode 1: eCPRI EtherType, 0: IPv4 EtherType, 2: fully random bytes
   task automatic make_frame(input int len, input int mode);
      frm_q.delete();
      for (int i = 0; i < len; i++) frm_q.push_back(8'($urandom));
      if (mode != 2) begin
         if (len > 12) frm_q[12] = (mode == 1) ? 8'hAE : 8'h08;
         if (len > 13) frm_q[13] = (mode == 1) ? 8'hFE : 8'h00;
      end
   endtask

   // Reference verdict: legal length, eCPRI EtherType and no MAC error.
   function automatic bit exp_good(input bit err);
      int n = frm_q.size();
      if (err || n < MIN_LEN || n > MAX_LEN) return 1'b0;
      return (frm_q[12] == 8'hAE) && (frm_q[13] == 8'hFE);
   endfunction

   // Reference write count: bytes are stored from index 0 up to the first
   // bad EtherType byte (inclusive), never beyond MAX_LEN bytes.
   function automatic int exp_writes();
      int n = frm_q.size();
      if (n > MAX_LEN) n = MAX_LEN;
      if (frm_q.size() > 12 && frm_q[12] != 8'hAE) begin
         if (n > 13) n = 13;
      end else if (frm_q.size() > 13 && frm_q[13] != 8'hFE) begin
         if (n > 14) n = 14;
      end
      return n;
   endfunction

   // Drives the first nb bytes of frm_q; called and returns at posedge+1.
   task automatic drive_frame(input bit err, input bit gaps, input int nb);
      int  wait_cyc;
      bit  acc;
      bit  last;
      driving = 1'b1;
      for (int i = 0; i < nb; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               bus.in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         last         = (i == frm_q.size() - 1);
         bus.in_valid = 1'b1;
         bus.in_data  = frm_q[i];
         bus.in_last  = last;
         bus.in_err   = last ? err : 1'($urandom_range(0, 1));
         wait_cyc     = 0;
         acc          = 1'b0;
         while (!acc && wait_cyc < 100) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk); #1;
            if (!acc) wait_cyc++;
         end
         if (!acc) begin
            chk("beat_accept_timeout", 32'(i), 32'hFFFF_FFFF);
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_err   = 1'b0;
      driving      = 1'b0;
   endtask

   task automatic clear_obs();
      wr_a_q.delete();
      wr_d_q.delete();
      rx_cyc_q.delete();
      rx_len_q.delete();
      ready_low = 0;
   endtask

   task automatic check_writes(input int nwr);
      chk("wr_count", 32'(wr_a_q.size()), 32'(nwr));
      for (int i = 0; i < wr_a_q.size() && i < nwr; i++) begin
         chk("wr_addr", 32'(wr_a_q[i]), 32'(i));
         chk("wr_data", 32'(wr_d_q[i]), 32'(frm_q[i]));
      end
   endtask

   task automatic run_frame(input bit err, input bit gaps);
      int  n     = frm_q.size();
      bit  good  = exp_good(err);
      int  nwr   = exp_writes();
      clear_obs();
      drive_frame(err, gaps, n);
      repeat (3) @(posedge clk);
      #1;
      chk("ready_gap", 32'(ready_low), 0);
      check_writes(nwr);
      if (good) begin
         exp_ok++;
         chk("recv_count", 32'(rx_cyc_q.size()), 1);
         if (rx_cyc_q.size() > 0) begin
            chk("recv_delay", 32'(rx_cyc_q[0] - last_acc_cyc), 2);
            chk("recv_len", 32'(rx_len_q[0]), 32'(n));
         end
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         chk("ready_wait_done", 32'(bus.in_ready), 0);
         chk("pkt_len_held", 32'(bus.pkt_len), 32'(n));
         bus.pkt_done = 1'b1;
         @(posedge clk); #1;
         bus.pkt_done = 1'b0;
         chk("ready_after_done", 32'(bus.in_ready), 1);
         chk("recv_count_after", 32'(rx_cyc_q.size()), 1);
      end else begin
         exp_drop++;
         chk("recv_on_drop", 32'(rx_cyc_q.size()), 0);
         chk("ready_after_drop", 32'(bus.in_ready), 1);
      end
      chk("frames_ok", 32'(bus.frames_ok), 32'(exp_ok));
      chk("frames_drop", 32'(bus.frames_drop), 32'(exp_drop));
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_addr_0", 32'(bus.addr_0), 0);
      chk("rst_data_0", 32'(bus.data_0), 0);
      chk("rst_cs_0", 32'(bus.cs_0), 0);
      chk("rst_we_0", 32'(bus.we_0), 0);
      chk("rst_oe_0", 32'(bus.oe_0), 1);
      chk("rst_recv_pkt", 32'(bus.recv_pkt), 0);
      chk("rst_pkt_len", 32'(bus.pkt_len), 0);
      chk("rst_frames_ok", 32'(bus.frames_ok), 0);
      chk("rst_frames_drop", 32'(bus.frames_drop), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.in_err   = 1'b0;
      bus.pkt_done = 1'b0;
      reset        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      reset = 1'b0;
      @(posedge clk); #1;

      // Good 64-byte eCPRI frame, continuous valid.
      make_frame(64, 1);
      run_frame(1'b0, 1'b0);

      // Wrong EtherType: only indices 0..12 are stored.
      make_frame(64, 0);
      run_frame(1'b0, 1'b0);

      // Too short, then MAC error on the last beat.
      make_frame(17, 1);
      run_frame(1'b0, 1'b0);
      make_frame(64, 1);
      run_frame(1'b1, 1'b0);

      // Minimum legal length, with a stray pkt_done while idle first.
      bus.pkt_done = 1'b1;
      @(posedge clk); #1;
      bus.pkt_done = 1'b0;
      chk("ready_idle_done", 32'(bus.in_ready), 1);
      make_frame(MIN_LEN, 1);
      run_frame(1'b0, 1'b0);

      // Oversized frame followed immediately by a 60-byte good frame.
      make_frame(1600, 1);
      clear_obs();
      drive_frame(1'b0, 1'b0, 1600);
      chk("long_ready_gap", 32'(ready_low), 0);
      check_writes(MAX_LEN);
      exp_drop++;
      make_frame(60, 1);
      run_frame(1'b0, 1'b0);

      // Random frames: lengths, EtherTypes, errors and valid gaps.
      for (int k = 0; k < 10; k++) begin
         make_frame($urandom_range(1, 80), ($urandom_range(0, 3) != 0) ? 1 : int'($urandom_range(0, 2)));
         run_frame(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      end

      // 100-byte good frame with gappy valid.
      make_frame(100, 1);
      run_frame(1'b0, 1'b1);

      // Second frame aborted by reset at byte 40.
      make_frame(100, 1);
      clear_obs();
      drive_frame(1'b0, 1'b1, 40);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset_vals();
      exp_ok   = 0;
      exp_drop = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("recv_after_abort", 32'(rx_cyc_q.size()), 0);
      chk("ok_after_abort", 32'(bus.frames_ok), 0);
      chk("drop_after_abort", 32'(bus.frames_drop), 0);

      // Next frame must start again at address 0.
      make_frame(30, 1);
      run_frame(1'b0, 1'b0);

      chk("oe_during_write", 32'(oe_bad), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
